// File: rtl/modadd_rr_sched_pkg.sv
// Shared constants for the round-robin modular-add scheduler.
// The op encodings exist only when MODADD_SCHED_SUB_EN is defined.
package modadd_rr_sched_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 12;
    localparam logic [11:0] KYBER_Q        = 12'd3329;

`ifdef MODADD_SCHED_SUB_EN
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
`endif

endpackage

// File: rtl/modadd_rr_sched_if.sv
// Requester/response bundle of the scheduler; master = lane side, slave = scheduler.
// req_op/rsp_op are present only when MODADD_SCHED_SUB_EN is defined.
interface modadd_rr_sched_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 12
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_x;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_y;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_z;
    logic [ID_W-1:0]               rsp_id;
`ifdef MODADD_SCHED_SUB_EN
    logic [NUM_REQ-1:0]            req_op;
    logic                          rsp_op;
`endif

`ifdef MODADD_SCHED_SUB_EN
    modport master (
        output req_valid, req_x, req_y, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_id, rsp_op
    );
    modport slave (
        input  req_valid, req_x, req_y, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_id, rsp_op
    );
`else
    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_id
    );
    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_id
    );
`endif

endinterface

// File: rtl/modadd_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module modadd_rr_sched_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [ID_W:0]   candSum;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        candSum = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            candSum = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (candSum >= (ID_W+1)'(NUM_REQ)) begin
                candSum = candSum - (ID_W+1)'(NUM_REQ);
            end
            cand = candSum[ID_W-1:0];
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/modadd_rr_sched.sv
// Round-robin scheduler sharing a two-stage modular adder (mod Q) among NUM_REQ lanes.
// Define MODADD_SCHED_SUB_EN to add per-request add/subtract selection.
module modadd_rr_sched
    import modadd_rr_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = 4,
    parameter int Q          = int'(KYBER_Q)
) (
    input  logic clk,
    input  logic rst,
    modadd_rr_sched_if.slave bus
);

    localparam int                  ID_W = $clog2(NUM_REQ);
    localparam logic [DATA_WIDTH:0] QW   = (DATA_WIDTH+1)'(Q);

    logic                  adv;
    logic                  xfer;
    logic                  anyReq;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grantIdx;
    logic [DATA_WIDTH-1:0] selX;
    logic [DATA_WIDTH-1:0] selY;
    logic [DATA_WIDTH:0]   sumW;
    logic [DATA_WIDTH-1:0] redZ;

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  s1Valid_q, s1Valid_d;
    logic [DATA_WIDTH-1:0] s1X_q, s1X_d;
    logic [DATA_WIDTH-1:0] s1Y_q, s1Y_d;
    logic [ID_W-1:0]       s1Id_q, s1Id_d;
    logic                  rspValid_q, rspValid_d;
    logic [DATA_WIDTH-1:0] rspZ_q, rspZ_d;
    logic [ID_W-1:0]       rspId_q, rspId_d;
`ifdef MODADD_SCHED_SUB_EN
    logic                  selOp;
    logic [DATA_WIDTH:0]   diffW;
    logic                  s1Op_q, s1Op_d;
    logic                  rspOp_q, rspOp_d;
`endif

    modadd_rr_sched_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grantIdx),
        .any_o   (anyReq)
    );

    // The whole pipe moves only when S2 is empty or being drained this cycle.
    assign adv           = !rspValid_q || bus.rsp_ready;
    assign xfer          = anyReq && adv && !rst;
    assign bus.req_ready = grant & {NUM_REQ{adv && !rst}};

    always_comb begin
        selX = '0;
        selY = '0;
`ifdef MODADD_SCHED_SUB_EN
        selOp = OP_ADD;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                selX = bus.req_x[i*DATA_WIDTH +: DATA_WIDTH];
                selY = bus.req_y[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef MODADD_SCHED_SUB_EN
                selOp = bus.req_op[i];
`endif
            end
        end
    end

    // Single conditional correction: exact only while both operands are below Q.
    always_comb begin
        sumW = {1'b0, s1X_q} + {1'b0, s1Y_q};
        redZ = (sumW >= QW) ? DATA_WIDTH'(sumW - QW) : sumW[DATA_WIDTH-1:0];
`ifdef MODADD_SCHED_SUB_EN
        diffW = {1'b0, s1X_q} - {1'b0, s1Y_q};
        if (s1Op_q == OP_SUB) begin
            redZ = diffW[DATA_WIDTH] ? DATA_WIDTH'(diffW + QW) : diffW[DATA_WIDTH-1:0];
        end
`endif
    end

    always_comb begin
        ptr_d      = ptr_q;
        s1Valid_d  = s1Valid_q;
        s1X_d      = s1X_q;
        s1Y_d      = s1Y_q;
        s1Id_d     = s1Id_q;
        rspValid_d = rspValid_q;
        rspZ_d     = rspZ_q;
        rspId_d    = rspId_q;
`ifdef MODADD_SCHED_SUB_EN
        s1Op_d     = s1Op_q;
        rspOp_d    = rspOp_q;
`endif
        if (adv) begin
            s1Valid_d  = xfer;
            rspValid_d = s1Valid_q;
            rspZ_d     = redZ;
            rspId_d    = s1Id_q;
`ifdef MODADD_SCHED_SUB_EN
            rspOp_d    = s1Op_q;
`endif
            if (xfer) begin
                ptr_d  = (grantIdx == ID_W'(NUM_REQ-1)) ? '0 : grantIdx + ID_W'(1);
                s1X_d  = selX;
                s1Y_d  = selY;
                s1Id_d = grantIdx;
`ifdef MODADD_SCHED_SUB_EN
                s1Op_d = selOp;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            s1Valid_q  <= 1'b0;
            s1X_q      <= '0;
            s1Y_q      <= '0;
            s1Id_q     <= '0;
            rspValid_q <= 1'b0;
            rspZ_q     <= '0;
            rspId_q    <= '0;
`ifdef MODADD_SCHED_SUB_EN
            s1Op_q     <= 1'b0;
            rspOp_q    <= 1'b0;
`endif
        end else begin
            ptr_q      <= ptr_d;
            s1Valid_q  <= s1Valid_d;
            s1X_q      <= s1X_d;
            s1Y_q      <= s1Y_d;
            s1Id_q     <= s1Id_d;
            rspValid_q <= rspValid_d;
            rspZ_q     <= rspZ_d;
            rspId_q    <= rspId_d;
`ifdef MODADD_SCHED_SUB_EN
            s1Op_q     <= s1Op_d;
            rspOp_q    <= rspOp_d;
`endif
        end
    end

    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_z     = rspZ_q;
    assign bus.rsp_id    = rspId_q;
`ifdef MODADD_SCHED_SUB_EN
    assign bus.rsp_op    = rspOp_q;
`endif

endmodule

// File: tb/tb_modadd_rr_sched.sv
// Directed bench for modadd_rr_sched (4 requesters, Q = 3329).
// Subtract vectors run only when MODADD_SCHED_SUB_EN is defined.
module tb_modadd_rr_sched;
    import modadd_rr_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DW      = 12;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] opX [NUM_REQ];
    logic [DW-1:0] opY [NUM_REQ];
    logic [NUM_REQ-1:0] opOp;
    logic [DW-1:0] fairZ [NUM_REQ];

    always #5 clk = ~clk;

    modadd_rr_sched_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

    assign bus.req_x = {opX[3], opX[2], opX[1], opX[0]};
    assign bus.req_y = {opY[3], opY[2], opY[1], opY[0]};
`ifdef MODADD_SCHED_SUB_EN
    assign bus.req_op = opOp;
`endif

    modadd_rr_sched #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NUM_REQ),
        .Q          (3329)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic rdy);
        bus.req_valid = valid;
        bus.rsp_ready = rdy;
    endtask

    // One isolated operation: accepted at once, result two edges later.
    task automatic singleOp(input string tag, input logic [1:0] idx, input logic [DW-1:0] x,
                            input logic [DW-1:0] y, input logic op, input logic [DW-1:0] expZ);
        opX[idx]  = x;
        opY[idx]  = y;
        opOp[idx] = op;
        applyStimulus(4'b0001 << idx, 1'b1);
        #1;
        checkOutput({tag, "_ready"}, 32'(bus.req_ready), 32'(4'b0001 << idx));
        tick();
        applyStimulus(4'b0000, 1'b1);
        checkOutput({tag, "_lat1"}, 32'(bus.rsp_valid), 32'd0);
        tick();
        checkOutput({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        checkOutput({tag, "_z"}, 32'(bus.rsp_z), 32'(expZ));
        checkOutput({tag, "_id"}, 32'(bus.rsp_id), 32'(idx));
`ifdef MODADD_SCHED_SUB_EN
        checkOutput({tag, "_op"}, 32'(bus.rsp_op), 32'(op));
`endif
        tick();
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            opX[i] = '0;
            opY[i] = '0;
        end
        opOp = '0;

        rst = 1'b1;
        applyStimulus(4'b1111, 1'b1);
        tick();
        tick();
        checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_z", 32'(bus.rsp_z), 32'd0);
        checkOutput("rst_id", 32'(bus.rsp_id), 32'd0);
        checkOutput("rst_ptr", 32'(dut.ptr_q), 32'd0);
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b1);
        tick();

        singleOp("single", 2'd2, 12'd3000, 12'd500, 1'b0, 12'd171);
        checkOutput("single_ptr", 32'(dut.ptr_q), 32'd3);

        singleOp("bnd_q", 2'd0, 12'd1664, 12'd1665, 1'b0, 12'd0);
        singleOp("bnd_qm1", 2'd1, 12'd1664, 12'd1664, 1'b0, 12'd3328);
        singleOp("bnd_zero", 2'd2, 12'd0, 12'd0, 1'b0, 12'd0);
        singleOp("bnd_max", 2'd3, 12'd3328, 12'd3328, 1'b0, 12'd3327);
        checkOutput("wrap_ptr", 32'(dut.ptr_q), 32'd0);

        // All lanes valid for eight grants: x = 3000+100i, y = 200+i.
        fairZ[0] = 12'd3200;
        fairZ[1] = 12'd3301;
        fairZ[2] = 12'd73;
        fairZ[3] = 12'd174;
        for (int i = 0; i < NUM_REQ; i++) begin
            opX[i]  = 12'(3000 + 100 * i);
            opY[i]  = 12'(200 + i);
            opOp[i] = 1'b0;
        end
        applyStimulus(4'b1111, 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c == 8) applyStimulus(4'b0000, 1'b1);
            #1;
            if (c < 8) checkOutput("fair_ready", 32'(bus.req_ready), 32'(4'b0001 << (c % 4)));
            if (c < 2) begin
                checkOutput("fair_fill", 32'(bus.rsp_valid), 32'd0);
            end else begin
                checkOutput("fair_valid", 32'(bus.rsp_valid), 32'd1);
                checkOutput("fair_id", 32'(bus.rsp_id), 32'((c - 2) % 4));
                checkOutput("fair_z", 32'(bus.rsp_z), 32'(fairZ[(c - 2) % 4]));
            end
            tick();
        end
        checkOutput("fair_drain", 32'(bus.rsp_valid), 32'd0);

        // Backpressure: fill S1/S2 with ops 0 and 1, then stall five cycles.
        applyStimulus(4'b1111, 1'b1);
        #1;
        checkOutput("bp_ready0", 32'(bus.req_ready), 32'd1);
        tick();
        checkOutput("bp_ready1", 32'(bus.req_ready), 32'd2);
        tick();
        applyStimulus(4'b1111, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("bp_stall_ready", 32'(bus.req_ready), 32'd0);
            checkOutput("bp_stall_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("bp_stall_id", 32'(bus.rsp_id), 32'd0);
            checkOutput("bp_stall_z", 32'(bus.rsp_z), 32'd3200);
            checkOutput("bp_stall_ptr", 32'(dut.ptr_q), 32'd2);
            tick();
        end
        applyStimulus(4'b1111, 1'b1);
        #1;
        checkOutput("bp_rel_ready", 32'(bus.req_ready), 32'd4);
        tick();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("bp_rel_id1", 32'(bus.rsp_id), 32'd1);
        checkOutput("bp_rel_z1", 32'(bus.rsp_z), 32'd3301);
        checkOutput("bp_rel_v1", 32'(bus.rsp_valid), 32'd1);
        tick();
        checkOutput("bp_rel_id2", 32'(bus.rsp_id), 32'd2);
        checkOutput("bp_rel_z2", 32'(bus.rsp_z), 32'd73);
        checkOutput("bp_rel_v2", 32'(bus.rsp_valid), 32'd1);
        tick();
        checkOutput("bp_rel_end", 32'(bus.rsp_valid), 32'd0);
        checkOutput("bp_rel_ptr", 32'(dut.ptr_q), 32'd3);

        // Reset with both stages occupied (op3 in S2, op0 in S1).
        applyStimulus(4'b1111, 1'b1);
        tick();
        tick();
        checkOutput("mid_pre_id", 32'(bus.rsp_id), 32'd3);
        rst = 1'b1;
        applyStimulus(4'b0110, 1'b1);
        #1;
        checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mid_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mid_z", 32'(bus.rsp_z), 32'd0);
        checkOutput("mid_ptr", 32'(dut.ptr_q), 32'd0);
        checkOutput("mid_s1", 32'(dut.s1Valid_q), 32'd0);
        checkOutput("mid_grant", 32'(bus.req_ready), 32'd2);
        tick();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("mid_s1only", 32'(bus.rsp_valid), 32'd0);
        tick();
        checkOutput("mid_post_v", 32'(bus.rsp_valid), 32'd1);
        checkOutput("mid_post_id", 32'(bus.rsp_id), 32'd1);
        checkOutput("mid_post_z", 32'(bus.rsp_z), 32'd3301);
        tick();

`ifdef MODADD_SCHED_SUB_EN
        singleOp("sub_neg", 2'd0, 12'd5, 12'd10, OP_SUB, 12'd3324);
        singleOp("sub_pos", 2'd1, 12'd10, 12'd5, OP_SUB, 12'd5);
        singleOp("sub_wrap", 2'd2, 12'd0, 12'd3328, OP_SUB, 12'd1);
        singleOp("sub_add", 2'd3, 12'd3000, 12'd500, OP_ADD, 12'd171);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modadd_rr_sched.md
Name: modadd_rr_sched

Overview:
- Round-robin scheduler that time-shares one pipelined modular adder (modulus Q = 3329, the Kyber prime) among NUM_REQ requesters, e.g. NTT butterfly lanes.
- Each requester has a valid/ready operand port.
- Results leave on a single valid/ready response port, tagged with the requester index.
- Sits between the lane controllers and the shared reduction datapath in the multi-lane NTT core.

Parameters:
- DATA_WIDTH, 12, operand/result width.
- NUM_REQ, 4, number of requesters (2..16).
- Q, 3329, modulus; requires Q < 2^DATA_WIDTH.
- ID_W, $clog2(NUM_REQ), width of the response tag (derived localparam).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_x  in  NUM_REQ*DATA_WIDTH  packed operand x; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_y  in  NUM_REQ*DATA_WIDTH  packed operand y, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_z  out  DATA_WIDTH  (x+y) mod Q.
- rsp_id  out  ID_W  index of the requester that issued the operation.

Behaviour:
- Two register stages:
  - S1 holds the granted operands and ID.
  - S2 holds the reduced result; S2 drives rsp_*.
- Advance enable: adv = !rsp_valid || rsp_ready. When adv=0, S1, S2 and the RR pointer all hold, and every req_ready bit is 0.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit becomes grant; req_ready = grant & {NUM_REQ{adv}}.
  - req_ready never depends on the requester's own req_valid being low; ready is only asserted to a valid requester.
- Handshake: a transfer occurs on req_valid[i] && req_ready[i]. Requesters must hold valid and data stable until accepted.
- Pointer:
  - On a transfer from i, ptr <= (i+1) mod NUM_REQ.
  - No transfer leaves ptr unchanged.
  - Wrap from NUM_REQ-1 goes to 0.
- S1 on adv:
  - s1_valid <= any transfer.
  - Operands and ID are loaded only on a transfer; otherwise they hold.
- S2 on adv:
  - rsp_valid <= s1_valid.
  - rsp_z <= reduce(s1_x + s1_y); rsp_id <= s1_id.
- Arithmetic:
  - Form a DATA_WIDTH+1-bit sum s.
  - If s >= Q, output s-Q; otherwise output s.
  - This is a single conditional subtraction, so the result is exact for x,y < Q.
  - Operands >= Q are outside the contract; the output is the single-subtraction value, with no flag.
- Latency: exactly 2 cycles from transfer to rsp_valid when unstalled. Throughput is 1 op/cycle.
- Ordering: responses appear in grant order. No reordering and no drop under backpressure.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- Reset: rst=1 at a clock edge produces:
  - ptr=0, s1_valid=0, rsp_valid=0, rsp_z=0, rsp_id=0.
  - req_ready=0 in the cycle rst is high.
  - In-flight operations are discarded, including mid-stall; data registers are also cleared.
- Simultaneous events: while S2 is presented and consumed (rsp_ready=1), S1 moves to S2 and a new grant enters S1 in the same cycle.

Optional Feature:
- Macro: MODADD_SCHED_SUB_EN.
- When defined:
  - Adds port req_op  in  NUM_REQ  (0 = add, 1 = subtract), latched into S1 with the operands.
  - Subtract computes (x - y) mod Q: form x - y; if it borrows, add Q.
  - Adds port rsp_op  out  1, echoing the latched op.
- When undefined:
  - Neither port exists.
  - All operations are additions; behaviour is identical to the base description.

Decomposition:
- Shared package (e.g. ntt_pkg): the modulus constant KYBER_Q = 12'd3329 and a DATA_WIDTH default of 12.
- Shared package, under the macro: op-encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
- Natural sub-module: rr_pick, a combinational round-robin priority picker (inputs req vector and ptr; outputs one-hot grant and its index).
- The reduction logic stays inline in S2.

Test Plan:
- Single op: requester 2 sends x=3000, y=500 -> 2 cycles later rsp_z=171, rsp_id=2.
- Reduction boundaries, one op per requester:
  - 1664+1665 -> 0.
  - 1664+1664 -> 3328.
  - 0+0 -> 0.
  - 3328+3328 -> 3327.
- All 4 requesters held valid for 8 cycles with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,2,3; one response per cycle after a 2-cycle fill.
- Backpressure: rsp_ready=0 for 5 cycles while requests are pending -> rsp_z/rsp_id stable, all req_ready=0, ptr held; on release, no result is lost or duplicated.
- Reset mid-stream: assert rst with S1 and S2 full -> next cycle rsp_valid=0 and ptr=0; the first post-reset grant goes to the lowest valid index.
- With MODADD_SCHED_SUB_EN: 5-10 -> 3324; 10-5 -> 5; 0-3328 -> 1; rsp_op echoes 1.
